// File: rtl/pwm_deadtime_sched.sv
// pwm_deadtime_sched: complementary PWM scheduler for one half-bridge leg.
// A free-running period counter is compared against the active duty to form
// the raw PWM level. A five-state sequencer drives the gate pair through
// explicit dead-time states. Duty updates arrive over a valid/ready handshake
// into a one-deep shadow register and are applied only on period boundaries.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           run enable; low forces gates off and holds the counter at 0
//   brake        immediate gate-off request, overrides en and duty
//   duty         requested high-side on-count
//   duty_vld     duty is valid
//   duty_rdy     shadow register empty (combinational, low during rst)
//   dt_cfg       dead-time setting, dead time = dt_cfg+1 clocks
//   high_out     high-side gate, registered
//   low_out      low-side gate, registered
//   period_start registered pulse on the cnt==0 cycle following a wrap
module pwm_deadtime_sched #(
    parameter int unsigned CNT_W = 10,
    parameter int unsigned DT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             brake,
    input  logic [CNT_W-1:0] duty,
    input  logic             duty_vld,
    output logic             duty_rdy,
    input  logic [DT_W-1:0]  dt_cfg,
    output logic             high_out,
    output logic             low_out,
    output logic             period_start
);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_DT_H = 3'd1,
        S_HIGH = 3'd2,
        S_DT_L = 3'd3,
        S_LOW  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_act;
    logic [CNT_W-1:0] shadow;
    logic             shadow_full;
    logic [DT_W-1:0]  dt_act;
    logic [DT_W-1:0]  dtc;
    logic [DT_W-1:0]  dtc_nxt;
    state_t           state;
    state_t           state_nxt;

    logic run;
    logic wrap;
    logic raw;
    logic xfer;
    logic apply;

    assign run      = en & ~brake;
    assign wrap     = run & (cnt == CNT_MAX);
    assign raw      = (cnt < duty_act);
    assign duty_rdy = ~shadow_full & ~rst;
    assign xfer     = duty_vld & duty_rdy;
    // Period boundary while running, or any cycle while disabled.
    assign apply    = wrap | ~en;

    // Period counter and period-start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            if (!en) begin
                cnt <= '0;
            end else if (!brake) begin
                cnt <= cnt + CNT_W'(1);
            end
            period_start <= wrap;
        end
    end

    // Shadow register and active duty / dead-time configuration.
    // A transfer needs shadow_full=0 and an apply needs shadow_full=1, so the
    // two branches can never compete in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= '0;
            shadow_full <= 1'b0;
            duty_act    <= '0;
            dt_act      <= '0;
        end else begin
            if (xfer) begin
                shadow      <= duty;
                shadow_full <= 1'b1;
            end else if (shadow_full && apply) begin
                duty_act    <= shadow;
                shadow_full <= 1'b0;
            end
            if (apply) begin
                dt_act <= dt_cfg;
            end
        end
    end

    // Sequencer state, dead-time counter and gate flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_OFF;
            dtc      <= '0;
            high_out <= 1'b0;
            low_out  <= 1'b0;
        end else begin
            state    <= state_nxt;
            dtc      <= dtc_nxt;
            high_out <= (state_nxt == S_HIGH);
            low_out  <= (state_nxt == S_LOW);
        end
    end

    // Next-state decode. The terminal test uses >= so that a dead time in
    // progress when dt_act shrinks at a wrap finishes instead of wrapping dtc.
    always_comb begin
        state_nxt = state;
        dtc_nxt   = dtc;
        if (!run) begin
            state_nxt = S_OFF;
            dtc_nxt   = '0;
        end else begin
            case (state)
                S_OFF: begin
                    state_nxt = raw ? S_DT_H : S_DT_L;
                    dtc_nxt   = '0;
                end
                S_DT_H: begin
                    if (!raw) begin
                        state_nxt = S_DT_L;
                        dtc_nxt   = '0;
                    end else if (dtc >= dt_act) begin
                        state_nxt = S_HIGH;
                        dtc_nxt   = '0;
                    end else begin
                        dtc_nxt = dtc + DT_W'(1);
                    end
                end
                S_DT_L: begin
                    if (raw) begin
                        state_nxt = S_DT_H;
                        dtc_nxt   = '0;
                    end else if (dtc >= dt_act) begin
                        state_nxt = S_LOW;
                        dtc_nxt   = '0;
                    end else begin
                        dtc_nxt = dtc + DT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!raw) begin
                        state_nxt = S_DT_L;
                        dtc_nxt   = '0;
                    end
                end
                S_LOW: begin
                    if (raw) begin
                        state_nxt = S_DT_H;
                        dtc_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_OFF;
                    dtc_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_sched.sv
// Testbench for pwm_deadtime_sched with CNT_W=4 (16-clock period).
// A reference model tracks how long raw has been stable in each direction and
// turns a gate on once that run covers dt_act+1 dead cycles.
module tb_pwm_deadtime_sched;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DT_W  = 5;
    localparam int          PER   = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             brake = 1'b0;
    logic [CNT_W-1:0] duty = '0;
    logic             duty_vld = 1'b0;
    logic             duty_rdy;
    logic [DT_W-1:0]  dt_cfg = '0;
    logic             high_out;
    logic             low_out;
    logic             period_start;

    always #5 clk = ~clk;

    pwm_deadtime_sched #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .brake        (brake),
        .duty         (duty),
        .duty_vld     (duty_vld),
        .duty_rdy     (duty_rdy),
        .dt_cfg       (dt_cfg),
        .high_out     (high_out),
        .low_out      (low_out),
        .period_start (period_start)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (values visible during the current cycle).
    int m_cnt = 0;
    int m_duty = 0;
    int m_dt = 0;
    int m_sh = 0;
    bit m_full = 1'b0;
    bit m_high = 1'b0;
    bit m_low = 1'b0;
    bit m_ps = 1'b0;
    bit m_hs = 1'b0;
    int run_h = 0;
    int run_l = 0;

    // Dead-gap monitor.
    int last_gate = 0;
    int gap = 0;
    int gap_min = 1000;

    // Random stimulus state.
    bit r_rst, r_en, r_brk, r_vld;
    int r_duty, r_dt;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit act, raw, wrap;
        int rh, rl;
        if (rst) begin
            m_cnt = 0; m_duty = 0; m_dt = 0; m_sh = 0; m_full = 0;
            m_high = 0; m_low = 0; m_ps = 0; m_hs = 0; run_h = 0; run_l = 0;
            return;
        end
        act  = en && !brake;
        raw  = m_cnt < m_duty;
        wrap = act && (m_cnt == PER - 1);
        rh = (act && raw) ? run_h + 1 : 0;
        rl = (act && !raw) ? run_l + 1 : 0;
        m_high = act && raw && (m_high || rh >= m_dt + 2);
        m_low  = act && !raw && (m_low || rl >= m_dt + 2);
        run_h = rh;
        run_l = rl;
        m_ps = wrap;
        m_hs = duty_vld && !m_full;
        if (m_hs) begin
            m_sh = int'(duty);
            m_full = 1'b1;
        end else if (m_full && (wrap || !en)) begin
            m_duty = m_sh;
            m_full = 1'b0;
        end
        if (wrap || !en) m_dt = int'(dt_cfg);
        if (!en) m_cnt = 0;
        else if (!brake) m_cnt = (m_cnt + 1) % PER;
    endtask

    task automatic observe();
        int cur;
        check("high_out", int'(high_out), int'(m_high));
        check("low_out", int'(low_out), int'(m_low));
        check("period_start", int'(period_start), int'(m_ps));
        check("gate_overlap", int'(high_out & low_out), 0);
        if (!high_out && !low_out) begin
            gap++;
            if (m_dt < gap_min) gap_min = m_dt;
        end else begin
            cur = high_out ? 1 : 2;
            if (last_gate != 0 && last_gate != cur)
                check("dead_gap_ge_dt1", int'(gap >= gap_min + 1), 1);
            last_gate = cur;
            gap = 0;
            gap_min = 1000;
        end
    endtask

    // One clock: drive at the falling edge, check duty_rdy, step, observe.
    task automatic cyc(input bit r, input bit e, input bit b, input int d,
                       input bit v, input int dt);
        rst = r; en = e; brake = b; duty = CNT_W'(d); duty_vld = v;
        dt_cfg = DT_W'(dt);
        #1;
        check("duty_rdy", int'(duty_rdy), int'(!m_full && !r));
        model_step();
        @(negedge clk);
        observe();
    endtask

    initial begin
        @(negedge clk);

        // Reset.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rst_high", int'(high_out), 0);
        check("rst_low", int'(low_out), 0);
        check("rst_ps", int'(period_start), 0);
        check("rst_rdy", int'(duty_rdy), 0);

        // duty=8, dt=2 loaded while disabled, then steady-state windows.
        cyc(0, 0, 0, 0, 0, 2);
        check("rdy_after_rst", int'(duty_rdy), 1);
        cyc(0, 0, 0, 8, 1, 2);
        cyc(0, 0, 0, 0, 0, 2);
        cyc(0, 0, 0, 0, 0, 2);
        for (int i = 0; i < 48; i++) begin
            cyc(0, 1, 0, 0, 0, 2);
            if (i >= 16) begin
                check("win8_high", int'(high_out), int'(m_cnt >= 4 && m_cnt <= 8));
                check("win8_low", int'(low_out), int'(m_cnt >= 12 || m_cnt == 0));
                check("win8_ps", int'(period_start), int'(m_cnt == 0));
            end
        end

        // Mid-period handshake at cnt=5, second request held until the wrap.
        for (int k = 0; k < 32 && m_cnt != 5; k++) cyc(0, 1, 0, 0, 0, 2);
        cyc(0, 1, 0, 12, 1, 2);
        check("shadow_full_rdy", int'(duty_rdy), 0);
        for (int k = 0; k < 11; k++) begin
            check("hold_rdy", int'(duty_rdy), int'(k == 10));
            cyc(0, 1, 0, 3, 1, 2);
        end
        for (int k = 0; k < 15; k++) begin
            cyc(0, 1, 0, 0, 0, 2);
            check("win12_high", int'(high_out), int'(m_cnt >= 4 && m_cnt <= 12));
        end

        // Brake while HIGH with duty=10.
        cyc(0, 1, 0, 10, 1, 2);
        for (int k = 0; k < 64 && !(m_high && m_cnt == 5 && m_duty == 10); k++)
            cyc(0, 1, 0, 0, 0, 2);
        check("reach_high", int'(high_out), 1);
        cyc(0, 1, 1, 0, 0, 2);
        check("brake_high_off", int'(high_out), 0);
        cyc(0, 1, 1, 0, 0, 2);
        cyc(0, 1, 1, 0, 0, 2);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0, 0, 2);
            check("release_dead_high", int'(high_out), 0);
            check("release_dead_low", int'(low_out), 0);
        end
        cyc(0, 1, 0, 0, 0, 2);
        check("release_gate_high", int'(high_out), 1);

        // Reset while in DT_H with the shadow full.
        for (int k = 0; k < 32 && m_cnt != 0; k++) cyc(0, 1, 0, 0, 0, 2);
        cyc(0, 1, 0, 5, 1, 2);
        cyc(0, 1, 0, 0, 0, 2);
        cyc(1, 1, 0, 0, 0, 2);
        check("midrst_high", int'(high_out), 0);
        check("midrst_low", int'(low_out), 0);
        check("midrst_rdy", int'(duty_rdy), 0);
        cyc(0, 0, 0, 0, 0, 2);
        check("post_rst_rdy", int'(duty_rdy), 1);
        for (int i = 0; i < 24; i++) begin
            cyc(0, 1, 0, 0, 0, 2);
            check("duty0_high", int'(high_out), 0);
            if (i >= 3) check("duty0_low", int'(low_out), 1);
        end

        // Randomized traffic.
        r_en = 1'b1;
        r_brk = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) r_en = !r_en;
            if (r_brk) r_brk = ($urandom_range(0, 3) != 0);
            else r_brk = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 5))
                0: r_duty = 0;
                1: r_duty = PER - 1;
                default: r_duty = int'($urandom_range(0, PER - 1));
            endcase
            r_vld = ($urandom_range(0, 3) == 0);
            r_dt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                               : int'($urandom_range(0, 4));
            cyc(r_rst, r_en, r_brk, r_duty, r_vld, r_dt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
